// File: rtl/ram_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_pkg
// Brief    : Shared types and width helpers for the south-terminal RAM_IO
//            access controller.
// Revision : 1.0 - initial release
// ============================================================================
package ram_io_pkg;

  // Access-controller operating state
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } state_t;

  // Default geometry, also used as the default pointer/counter sizing
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_FIFO_PTR_W = $clog2(DEF_FIFO_DEPTH) + 1;
  localparam int DEF_CNT_W      = 7;

  // Pointer width with one extra wrap bit so full and empty are distinct
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of a down/up counter that must hold values 0..max_val
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_io_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ram_io_rsp_fifo
// Brief    : Synchronous response FIFO with occupancy count and a registered
//            head word that holds its last value once the FIFO drains.
// Revision : 1.0 - initial release
// ============================================================================
module ram_io_rsp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_push_data,
  input  logic                   i_pop,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [DATA_W-1:0]      o_head_data
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [DATA_W-1:0] r_head;
  logic [PTR_W-1:0]  w_count;
  logic              w_pop;
  logic [IDX_W-1:0]  w_rd_next_idx;

  assign w_count       = r_wr_ptr - r_rd_ptr;
  assign w_pop         = i_pop && (w_count != '0);
  assign w_rd_next_idx = r_rd_ptr[IDX_W-1:0] + IDX_W'(1);
  assign o_count       = w_count;
  assign o_head_data   = r_head;

  // Storage array: written on every push, never reset
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
    end
  end

  // Pointers and head register; head tracks the word that will be at the
  // front after this edge, so it needs no read-port mux on the output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push && ((w_count == '0) || ((w_count == PTR_W'(1)) && w_pop))) begin
        r_head <= i_push_data;
      end else if (w_pop && (w_count > PTR_W'(1))) begin
        r_head <= r_mem[w_rd_next_idx];
      end
    end
  end

  // Credit flow control upstream must make a push into a full FIFO impossible
  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && (w_count == PTR_W'(DEPTH))));

endmodule
`default_nettype wire

// File: rtl/s_term_ram_io_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : s_term_ram_io_access_ctrl
// Brief    : Fabric-to-SRAM access sequencer for the south-terminal RAM_IO
//            tile: request issue, fixed-latency read capture into a credited
//            response FIFO, and idle sleep/wake sequencing of the macro.
// Revision : 1.0 - initial release
// ============================================================================
module s_term_ram_io_access_ctrl
  import ram_io_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 2,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int IDLE_TIMEOUT = 64,
  parameter int WAKE_CYCLES  = 3
) (
  input  logic              UserCLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_sleep,
  output logic              busy
);

  localparam int PTR_W  = fifo_ptr_w(FIFO_DEPTH);
  localparam int OUT_W  = PTR_W + 1;
  localparam int IDLE_W = cnt_w(IDLE_TIMEOUT);
  localparam int WAKE_W = cnt_w(WAKE_CYCLES);

  state_t            r_state;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [WAKE_W-1:0] r_wake_cnt;
  logic              r_sleep;
  logic              r_ce;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [RD_LAT-1:0] r_rd_pipe;

  logic [PTR_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_rsp_valid;
  logic              w_pop_credit;
  logic [OUT_W-1:0]  w_inflight;
  logic [OUT_W-1:0]  w_outstanding;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_push;

  // Reads in flight: the issue stage on the SRAM pins plus every latency stage
  always_comb begin
    w_inflight = OUT_W'(r_ce & ~r_we);
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + OUT_W'(r_rd_pipe[i]);
    end
  end

  // A pop frees its slot for this cycle's read unless the FIFO is full; in
  // that case inflight is zero and the freed credit only shows next cycle.
  assign w_rsp_valid   = (w_fifo_count != '0);
  assign w_fifo_full   = (w_fifo_count == PTR_W'(FIFO_DEPTH));
  assign w_pop_credit  = w_rsp_valid && rsp_ready && !w_fifo_full;
  assign w_outstanding = OUT_W'(w_fifo_count) + w_inflight - OUT_W'(w_pop_credit);
  assign w_req_ready   = !reset && (r_state == ST_ACTIVE) &&
                         (req_we || (w_outstanding < OUT_W'(FIFO_DEPTH)));
  assign w_accept      = req_valid && w_req_ready;
  assign w_push        = r_rd_pipe[RD_LAT-1];

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign ram_ce    = r_ce;
  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_sleep = r_sleep;
  assign busy      = (w_inflight != '0) || w_rsp_valid || (r_state == ST_WAKE);

  ram_io_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_rsp_fifo (
    .i_clk       (UserCLK),
    .i_rst       (reset),
    .i_push      (w_push),
    .i_push_data (ram_rdata),
    .i_pop       (rsp_ready),
    .o_count     (w_fifo_count),
    .o_head_data (rsp_data)
  );

  // Issue stage and read-latency tracker
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_ce      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_pipe <= '0;
    end else begin
      r_ce <= w_accept;
      r_we <= w_accept && req_we;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      r_rd_pipe[0] <= r_ce && !r_we;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

  // Power state machine: idle timeout into sleep, timed wake on demand
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_state    <= ST_ACTIVE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_sleep    <= 1'b0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (w_accept || w_rsp_valid) begin
            r_idle_cnt <= '0;
          end else if ((w_inflight == '0) && (IDLE_TIMEOUT != 0)) begin
            if (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
              r_state    <= ST_SLEEP;
              r_sleep    <= 1'b1;
              r_idle_cnt <= '0;
            end else begin
              r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
          end
        end
        ST_SLEEP: begin
          if (req_valid) begin
            r_state    <= ST_WAKE;
            r_sleep    <= 1'b0;
            r_wake_cnt <= WAKE_W'(WAKE_CYCLES - 1);
          end
        end
        ST_WAKE: begin
          if (r_wake_cnt == '0) begin
            r_state    <= ST_ACTIVE;
            r_idle_cnt <= '0;
          end else begin
            r_wake_cnt <= r_wake_cnt - WAKE_W'(1);
          end
        end
        default: begin
          r_state <= ST_ACTIVE;
          r_sleep <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
